// File: rtl/dm_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : dm_write_buffer
//  Purpose  : Posted-write buffer between the core MEM-stage data port (DM_*)
//             and a slower handshaked data memory. Stores are queued in a
//             FIFO and drained in the background. Loads are forwarded from the
//             buffer on an address hit (youngest entry wins), or fetched from
//             memory on a miss. dm_stall holds the core while a request
//             cannot complete this cycle.
//  Ports    : clk, rst (sync, active high)
//             DM_enable/DM_read/DM_write/DM_address/DM_in -> core request
//             DM_out (registered load data), dm_stall (combinational)
//             mem_req/mem_we/mem_addr/mem_wdata (registered) -> memory
//             mem_ack/mem_rdata <- memory completion
//  Config   : DM_WBUF_COALESCE_EN - a store that matches a buffered entry
//             which is not in flight overwrites that entry in place.
//  Revision : 1.0 - initial release
// ============================================================================
module dm_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DM_enable,
    input  logic              DM_read,
    input  logic              DM_write,
    input  logic [ADDR_W-1:0] DM_address,
    input  logic [DATA_W-1:0] DM_in,
    output logic [DATA_W-1:0] DM_out,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WR_BUSY = 2'd1;
    localparam logic [1:0] c_ST_RD_BUSY = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_q,     state_d;
    logic [c_PTR_W-1:0] head_q,      head_d;
    logic [c_PTR_W-1:0] tail_q,      tail_d;
    logic [c_CNT_W-1:0] count_q,     count_d;
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [ADDR_W-1:0]  addr_d [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [DATA_W-1:0]  data_d [DEPTH];
    logic [ADDR_W-1:0]  rd_addr_q,   rd_addr_d;
    logic               rd_done_q,   rd_done_d;
    logic [DATA_W-1:0]  dm_out_q,    dm_out_d;
    logic               mem_req_q,   mem_req_d;
    logic               mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    // ------------------------------------------------------------------
    // Request decode and buffer lookup
    // ------------------------------------------------------------------
    logic               w_wr;
    logic               w_rd;
    logic               w_ack;
    logic               w_wr_done;
    logic               w_rd_done;
    logic               w_miss;
    logic               w_space;
    logic               w_wr_acc;
    logic               w_push;
    logic               w_hit;
    logic [c_PTR_W-1:0] w_hit_idx;
    logic [c_PTR_W-1:0] w_idx;
`ifdef DM_WBUF_COALESCE_EN
    logic               w_co_hit;
    logic [c_PTR_W-1:0] w_co_idx;
`endif

    assign w_wr      = DM_enable & DM_write;
    assign w_rd      = DM_enable & DM_read & ~DM_write;
    // An ack only means something while a transaction is actually on the bus.
    assign w_ack     = mem_ack & mem_req_q;
    assign w_wr_done = (state_q == c_ST_WR_BUSY) & w_ack;
    assign w_rd_done = (state_q == c_ST_RD_BUSY) & w_ack;
    // rd_done_q marks the re-presented load that is answered from DM_out.
    assign w_miss    = w_rd & ~w_hit & ~rd_done_q;
    // A full buffer still accepts when the head retires in the same cycle.
    assign w_space   = (count_q < c_FULL) | w_wr_done;

    // Walk from oldest to youngest so the last match is the youngest one.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_idx     = '0;
`ifdef DM_WBUF_COALESCE_EN
        w_co_hit  = 1'b0;
        w_co_idx  = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = head_q + c_PTR_W'(k);
            if ((c_CNT_W'(k) < count_q) && (addr_q[w_idx] == DM_address)) begin
                w_hit     = 1'b1;
                w_hit_idx = w_idx;
`ifdef DM_WBUF_COALESCE_EN
                // The head is frozen once its write has been launched.
                if (!((k == 0) && (state_q == c_ST_WR_BUSY))) begin
                    w_co_hit = 1'b1;
                    w_co_idx = w_idx;
                end
`endif
            end
        end
    end

`ifdef DM_WBUF_COALESCE_EN
    assign w_wr_acc = w_wr & (w_co_hit | w_space);
    assign w_push   = w_wr_acc & ~w_co_hit;
`else
    assign w_wr_acc = w_wr & w_space;
    assign w_push   = w_wr_acc;
`endif

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (w_push) begin
            addr_d[tail_q] = DM_address;
            data_d[tail_q] = DM_in;
            tail_d         = tail_q + 1'b1;
        end
`ifdef DM_WBUF_COALESCE_EN
        if (w_wr_acc && w_co_hit) begin
            data_d[w_co_idx] = DM_in;
        end
`endif
        if (w_wr_done) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_wr_done);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_ST_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rd_addr_q   <= '0;
            rd_done_q   <= 1'b0;
            dm_out_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rd_addr_q   <= rd_addr_d;
            rd_done_q   <= rd_done_d;
            dm_out_q    <= dm_out_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Entry storage needs no reset: validity comes from count_q.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_miss) begin
                    state_d   = c_ST_RD_BUSY;
                    rd_addr_d = DM_address;
                end else if (count_q != '0) begin
                    state_d = c_ST_WR_BUSY;
                end
            end
            c_ST_WR_BUSY: if (w_wr_done) state_d = c_ST_IDLE;
            c_ST_RD_BUSY: if (w_rd_done) state_d = c_ST_IDLE;
            default:      state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dm_out_d    = dm_out_q;
        rd_done_d   = w_rd_done;
        dm_stall    = ~rst & ((w_wr & ~w_wr_acc) | w_miss);

        // Bus is launched on the first BUSY cycle and held until the ack.
        case (state_q)
            c_ST_WR_BUSY: begin
                if (w_ack) begin
                    mem_req_d = 1'b0;
                end else if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[head_q];
                    mem_wdata_d = data_q[head_q];
                end
            end
            c_ST_RD_BUSY: begin
                if (w_ack) begin
                    mem_req_d = 1'b0;
                end else if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = rd_addr_q;
                end
            end
            default: mem_req_d = 1'b0;
        endcase

        if (w_rd_done) begin
            dm_out_d = mem_rdata;
        end else if (w_rd && w_hit && !rd_done_q) begin
            dm_out_d = data_q[w_hit_idx];
        end
    end

    assign DM_out    = dm_out_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_write_buffer
//  Purpose  : Self-checking bench for dm_write_buffer. A program-order memory
//             image predicts every load result and the final memory content;
//             a pending-store list predicts the order of memory writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        DM_enable, DM_read, DM_write;
    logic [11:0] DM_address;
    logic [31:0] DM_in;
    logic [31:0] DM_out;
    logic        dm_stall;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dm_write_buffer #(.DEPTH(4), .ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
        .DM_address(DM_address), .DM_in(DM_in), .DM_out(DM_out),
        .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct packed { logic [11:0] a; logic [31:0] d; } st_t;
    typedef struct packed { logic we; logic [11:0] a; } tx_t;

    logic [31:0] mem_model [0:4095];   // what the memory really holds
    logic [31:0] golden    [0:4095];   // what a load must return (program order)
    st_t         pend[$];              // accepted stores not yet written
    tx_t         txlog[$];             // completed memory transactions

    int total = 0;
    int bad   = 0;
    int writes = 0, reads = 0, req_rises = 0;
    logic [11:0] last_wa;
    logic [31:0] last_wd;
    int stall_cycles;

    // memory responder controls
    bit auto_ack;
    int lat;
    int pulse_tok = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out, required completion", name);
    endtask

    // ------------------------------------------------------------------
    // Memory responder: ack after `lat` cycles of mem_req, or on demand.
    // ------------------------------------------------------------------
    initial begin
        int wcnt;
        int pulse_seen;
        wcnt = 0;
        pulse_seen = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (pulse_tok != pulse_seen) begin
                pulse_seen = pulse_tok;
                mem_ack = 1'b1;
                mem_rdata = mem_model[mem_addr];
            end else if (auto_ack && mem_req) begin
                if (wcnt >= lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_model[mem_addr];
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else if (!mem_req) begin
                wcnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process: runs every cycle at the falling edge.
    // ------------------------------------------------------------------
    initial begin
        bit          prev_req, prev_ack, ld_chk, ok;
        logic [44:0] prev_bus;
        logic [31:0] ld_exp;
        logic [11:0] exp_a;
        logic [31:0] exp_d;
        int          f;
        prev_req = 0; prev_ack = 0; ld_chk = 0; prev_bus = '0; ld_exp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                // stores still buffered are lost; memory keeps what was written
                for (int i = 0; i < 4096; i++) golden[i] = mem_model[i];
                pend.delete();
                ld_chk = 0; prev_req = 0; prev_ack = 0;
            end else begin
                if (ld_chk) begin
                    chk("load_data", DM_out, ld_exp);
                    ld_chk = 0;
                end
                if (mem_req && prev_req && !prev_ack)
                    chk("bus_stable", {mem_we, mem_addr, mem_wdata}, prev_bus);
                if (mem_req && !prev_req) req_rises++;
                if (mem_ack && mem_req) begin
                    txlog.push_back({mem_we, mem_addr});
                    if (mem_we) begin
                        f = -1;
                        for (int k = 0; k < pend.size(); k++)
                            if (f < 0 && pend[k].a == mem_addr && pend[k].d == mem_wdata) f = k;
`ifdef DM_WBUF_COALESCE_EN
                        // merged stores may skip older values of the same address
                        ok = (f >= 0) && (pend[0].a == mem_addr);
`else
                        ok = (f == 0);
`endif
                        exp_a = (pend.size() > 0) ? pend[0].a : 12'h0;
                        exp_d = (pend.size() > 0) ? pend[0].d : 32'h0;
                        total++;
                        if (!ok) begin
                            bad++;
                            $display("FAIL wr_order: got addr 0x%h data 0x%h, required addr 0x%h data 0x%h",
                                     mem_addr, mem_wdata, exp_a, exp_d);
                        end
                        if (f >= 0)
                            for (int k = f; k >= 0; k--)
                                if (pend[k].a == mem_addr) pend.delete(k);
                        mem_model[mem_addr] = mem_wdata;
                        writes++;
                        last_wa = mem_addr;
                        last_wd = mem_wdata;
                    end else begin
                        reads++;
                    end
                end
                if (DM_enable && DM_write && !dm_stall) begin
                    golden[DM_address] = DM_in;
                    pend.push_back({DM_address, DM_in});
                end else if (DM_enable && DM_read && !dm_stall) begin
                    ld_chk = 1;
                    ld_exp = golden[DM_address];
                end
                prev_req = mem_req;
                prev_ack = mem_ack;
                prev_bus = {mem_we, mem_addr, mem_wdata};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic drive_req(input logic w, input logic [11:0] a, input logic [31:0] d);
        DM_enable = 1'b1; DM_write = w; DM_read = ~w; DM_address = a; DM_in = d;
    endtask

    task automatic idle();
        DM_enable = 1'b0; DM_write = 1'b0; DM_read = 1'b0;
    endtask

    task automatic wait_accept(input string name);
        stall_cycles = 0;
        forever begin
            @(negedge clk);
            if (!dm_stall) break;
            stall_cycles++;
            if (stall_cycles > 200) begin
                timeout(name);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic store(input logic [11:0] a, input logic [31:0] d);
        drive_req(1'b1, a, d);
        wait_accept("store_accept");
    endtask

    task automatic load(input logic [11:0] a);
        drive_req(1'b0, a, 32'h0);
        wait_accept("load_accept");
    endtask

    task automatic wait_drain();
        int q, n;
        q = 0; n = 0;
        while (q < 4) begin
            @(negedge clk);
            n++;
            if (!mem_req && pend.size() == 0) q++; else q = 0;
            if (n > 400) begin
                timeout("drain");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_image(input string name);
        int m;
        m = 0;
        for (int i = 0; i < 4096; i++) if (mem_model[i] !== golden[i]) m++;
        chk(name, m, 0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int w0, r0, t0, n;
        for (int i = 0; i < 4096; i++) mem_model[i] = 32'hB0B0_0000 | i;
        mem_model[12'h030] = 32'hCAFE_0001;
        auto_ack = 0; lat = 0;
        rst = 1'b1;
        DM_enable = 1'b1; DM_write = 1'b1; DM_read = 1'b0;
        DM_address = 12'h100; DM_in = 32'h1234_5678;

        // reset held two cycles with a store presented
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dm_out", DM_out, 0);
        chk("rst_stall", dm_stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_req", req_rises, 0);

        // single posted store, ack 3 cycles after request
        auto_ack = 1; lat = 3; w0 = writes;
        store(12'h010, 32'hDEAD_BEEF);
        chk("post_stall", stall_cycles, 0);
        idle();
        wait_drain();
        chk("post_nwr", writes - w0, 1);
        chk("post_addr", last_wa, 12'h010);
        chk("post_data", last_wd, 32'hDEAD_BEEF);

        // fill the buffer with memory frozen; fifth store waits for the ack
        auto_ack = 0; w0 = writes;
        for (int i = 0; i < 4; i++) begin
            store(12'h100 + 12'(i), 32'h300 + i);
            chk("full_accept", stall_cycles, 0);
        end
        drive_req(1'b1, 12'h104, 32'h304);
        @(negedge clk);
        chk("full_stall", dm_stall, 1);
        pulse_tok++;
        @(negedge clk);
        chk("full_release", dm_stall, 0);
        @(posedge clk); #1;
        idle();
        auto_ack = 1; lat = 1;
        wait_drain();
        chk("full_nwr", writes - w0, 5);
        check_image("full_image");

        // forwarding of the youngest store to an address, no memory read
        auto_ack = 0; w0 = writes; r0 = reads;
        store(12'h020, 32'h1);
        store(12'h020, 32'h2);
        load(12'h020);
        idle();
        chk("fwd_data", DM_out, 32'h2);
        chk("fwd_stall", stall_cycles, 0);
        chk("fwd_noread", reads - r0, 0);
        auto_ack = 1; lat = 1;
        wait_drain();
`ifdef DM_WBUF_COALESCE_EN
        chk("fwd_nwr", writes - w0, 1);
`else
        chk("fwd_nwr", writes - w0, 2);
`endif
        check_image("fwd_image");

        // load miss with a 2-cycle memory
        auto_ack = 1; lat = 2; r0 = reads;
        load(12'h030);
        idle();
        chk("miss_data", DM_out, 32'hCAFE_0001);
        chk("miss_nrd", reads - r0, 1);
        chk("miss_stall", stall_cycles, 5);

        // a pending miss goes ahead of the second buffered store
        auto_ack = 0; t0 = txlog.size();
        store(12'h040, 32'h44);
        store(12'h041, 32'h45);
        auto_ack = 1; lat = 1;
        load(12'h050);
        idle();
        chk("prio_data", DM_out, 32'hB0B0_0050);
        wait_drain();
        if (txlog.size() < t0 + 3) begin
            timeout("prio_txlog");
        end else begin
            chk("prio_1st", {txlog[t0].we, txlog[t0].a}, {1'b1, 12'h040});
            chk("prio_2nd", {txlog[t0+1].we, txlog[t0+1].a}, {1'b0, 12'h050});
            chk("prio_3rd", {txlog[t0+2].we, txlog[t0+2].a}, {1'b1, 12'h041});
        end

        // reset while a write is in flight drops the buffer
        auto_ack = 0; w0 = writes;
        store(12'h060, 32'h66);
        store(12'h061, 32'h67);
        idle();
        n = 0;
        while (!mem_req && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rstmid_busy", mem_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_req", mem_req, 0);
        rst = 1'b0;
        auto_ack = 1; lat = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("rstmid_nwr", writes - w0, 0);
        load(12'h060);
        idle();
        chk("rstmid_load", DM_out, 32'hB0B0_0060);
        check_image("rstmid_image");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
